alpu_operand_fetch: RTL and testbench

- Consumer-side reader for the ALPU exchange buffer (xbuf).
- Accepts one instruction at a time, carrying up to two operand addresses.
- Issues consuming reads to the xbuf read port and retries each read until it hits.
- Presents the assembled operand pair plus opcode to the ALU over a valid/ready handshake.

---
 rtl/alpu_operand_fetch.sv | 185 ++++++++++++++++++
 tb/tb_alpu_operand_fetch.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alpu_operand_fetch.sv
// ALPU operand fetch: takes one instruction at a time, reads up to two operands from the xbuf
// (retrying each read until it hits), then issues them to the ALU. Optional stall counter: ALPU_OPF_STALL_CNT_EN.
//
// state   | meaning
// IDLE    | waiting for an instruction (req_ready_o high)
// FETCH_A | reading operand A from xbuf, retrying on miss
// FETCH_B | reading operand B from xbuf, retrying on miss
// ISSUE   | operand pair presented to ALU, held until iss_ready_i
module alpu_operand_fetch #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [OP_WIDTH-1:0]   req_op_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_a_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_b_i,
  input  logic                  req_need_a_i,
  input  logic                  req_need_b_i,
  output logic [ADDR_WIDTH-1:0] xbuf_raddr_o,
  output logic                  xbuf_rvalid_o,
  input  logic [DATA_WIDTH-1:0] xbuf_rdata_i,
  input  logic                  xbuf_rhit_i,
  output logic                  iss_valid_o,
  input  logic                  iss_ready_i,
  output logic [OP_WIDTH-1:0]   iss_op_o,
  output logic [DATA_WIDTH-1:0] iss_opa_o,
  output logic [DATA_WIDTH-1:0] iss_opb_o
`ifdef ALPU_OPF_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH_A = 2'd1,
    FETCH_B = 2'd2,
    ISSUE   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic                    req_ready_q, req_ready_d;
  logic [OP_WIDTH-1:0]     op_q, op_d;
  logic [ADDR_WIDTH-1:0]   addr_a_q, addr_a_d;
  logic [ADDR_WIDTH-1:0]   addr_b_q, addr_b_d;
  logic                    need_b_q, need_b_d;
  logic [DATA_WIDTH-1:0]   opa_q, opa_d;
  logic [DATA_WIDTH-1:0]   opb_q, opb_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic                    fetching;
  logic                    rd_valid;
  logic                    accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      op_q        <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      need_b_q    <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      raddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      op_q        <= op_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      need_b_q    <= need_b_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      raddr_q     <= raddr_d;
    end
  end

  always_comb begin
    fetching = (state_q == FETCH_A) || (state_q == FETCH_B);
    rd_valid = fetching && !flush_i;
    // req_ready_q is only ever high while in IDLE
    accept   = req_valid_i && req_ready_q && !flush_i;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    need_b_d = need_b_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    raddr_d  = raddr_q;

    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_d     = req_op_i;
            addr_a_d = req_addr_a_i;
            addr_b_d = req_addr_b_i;
            need_b_d = req_need_b_i;
            opa_d    = '0;
            opb_d    = '0;
            if (req_need_a_i) begin
              state_d = FETCH_A;
              raddr_d = req_addr_a_i;
            end else if (req_need_b_i) begin
              state_d = FETCH_B;
              raddr_d = req_addr_b_i;
            end else begin
              state_d = ISSUE;
            end
          end
        end
        FETCH_A: begin
          if (xbuf_rhit_i) begin
            opa_d = xbuf_rdata_i;
            // the hit consumed the entry, so a shared address must be reused for B
            if (need_b_q && (addr_b_q == addr_a_q)) begin
              opb_d   = xbuf_rdata_i;
              state_d = ISSUE;
            end else if (need_b_q) begin
              state_d = FETCH_B;
              raddr_d = addr_b_q;
            end else begin
              state_d = ISSUE;
            end
          end
        end
        FETCH_B: begin
          if (xbuf_rhit_i) begin
            opb_d   = xbuf_rdata_i;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (iss_ready_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    req_ready_d = (state_d == IDLE);
  end

  assign req_ready_o   = req_ready_q;
  assign xbuf_rvalid_o = rd_valid;
  assign xbuf_raddr_o  = raddr_q;
  assign iss_valid_o   = (state_q == ISSUE) && !flush_i;
  assign iss_op_o      = op_q;
  assign iss_opa_o     = opa_q;
  assign iss_opb_o     = opb_q;

`ifdef ALPU_OPF_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (rd_valid && !xbuf_rhit_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alpu_operand_fetch.sv
// Randomized self-checking bench for alpu_operand_fetch; the xbuf is modelled as a consuming
// memory with per-entry miss counts, and expectations come from a transaction-level model.
module tb_alpu_operand_fetch;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int OW = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [OW-1:0] req_op_i;
  logic [AW-1:0] req_addr_a_i;
  logic [AW-1:0] req_addr_b_i;
  logic          req_need_a_i;
  logic          req_need_b_i;
  logic [AW-1:0] xbuf_raddr_o;
  logic          xbuf_rvalid_o;
  logic [DW-1:0] xbuf_rdata_i;
  logic          xbuf_rhit_i;
  logic          iss_valid_o;
  logic          iss_ready_i;
  logic [OW-1:0] iss_op_o;
  logic [DW-1:0] iss_opa_o;
  logic [DW-1:0] iss_opb_o;
`ifdef ALPU_OPF_STALL_CNT_EN
  logic [15:0]   stall_cnt_o;
`endif

  alpu_operand_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_addr_a_i(req_addr_a_i), .req_addr_b_i(req_addr_b_i),
    .req_need_a_i(req_need_a_i), .req_need_b_i(req_need_b_i),
    .xbuf_raddr_o(xbuf_raddr_o), .xbuf_rvalid_o(xbuf_rvalid_o),
    .xbuf_rdata_i(xbuf_rdata_i), .xbuf_rhit_i(xbuf_rhit_i),
    .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i), .iss_op_o(iss_op_o),
    .iss_opa_o(iss_opa_o), .iss_opb_o(iss_opb_o)
`ifdef ALPU_OPF_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // xbuf model
  logic [DW-1:0] mem [256];
  bit            present [256];
  int            miss_left [256];
  logic [AW-1:0] rd_q [$];

  // per-cycle samples
  logic          s_rvalid, s_iss_valid, s_req_ready;
  logic [OW-1:0] s_op;
  logic [DW-1:0] s_opa, s_opb;

  // transaction-level expectations
  logic [AW-1:0] exp_rd [$];
  logic [DW-1:0] e_opa, e_opb;
  int            e_lat;
  int            stall_exp;

  // transaction results
  int            t_lat, t_unstable;
  bit            t_ready_after;
  logic [OW-1:0] t_op;
  logic [DW-1:0] t_opa, t_opb;

  task automatic tick();
    @(negedge clk);
    #1;
    xbuf_rhit_i  = 1'b0;
    xbuf_rdata_i = $urandom;
    if (xbuf_rvalid_o === 1'b1) begin
      int a;
      a = int'(xbuf_raddr_o);
      rd_q.push_back(xbuf_raddr_o);
      if (miss_left[a] > 0) begin
        miss_left[a] = miss_left[a] - 1;
      end else if (present[a]) begin
        xbuf_rhit_i  = 1'b1;
        xbuf_rdata_i = mem[a];
        present[a]   = 1'b0;
      end
    end
    #1;
    s_rvalid    = xbuf_rvalid_o;
    s_iss_valid = iss_valid_o;
    s_req_ready = req_ready_o;
    s_op        = iss_op_o;
    s_opa       = iss_opa_o;
    s_opb       = iss_opb_o;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_xbuf();
    for (int i = 0; i < 256; i++) begin
      present[i]   = 1'b0;
      miss_left[i] = 0;
    end
  endtask

  // Loads the xbuf model and derives the expected reads, operands and latency.
  task automatic prep(input logic [AW-1:0] a, input logic [AW-1:0] b, input bit na, input bit nb,
                      input int ma, input int mb, input logic [DW-1:0] da, input logic [DW-1:0] db);
    bit same;
    int mbe;
    logic [DW-1:0] dbe;
    same = (a == b);
    mem[a] = da; present[a] = 1'b1; miss_left[a] = ma;
    if (!same) begin
      mem[b] = db; present[b] = 1'b1; miss_left[b] = mb;
    end
    mbe = same ? ma : mb;
    dbe = same ? da : db;
    exp_rd.delete();
    if (na) repeat (ma + 1) exp_rd.push_back(a);
    if (nb && !(na && same)) repeat (mbe + 1) exp_rd.push_back(b);
    e_opa = na ? da : '0;
    e_opb = nb ? dbe : '0;
    e_lat = exp_rd.size() + 1;
    stall_exp += (na ? ma : 0) + ((nb && !(na && same)) ? mbe : 0);
  endtask

  task automatic do_txn(input logic [OW-1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input bit na, input bit nb, input int hold);
    bit acc;
    rd_q.delete();
    req_op_i = op; req_addr_a_i = a; req_addr_b_i = b;
    req_need_a_i = na; req_need_b_i = nb;
    req_valid_i = 1'b1; iss_ready_i = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_req_ready === 1'b1) begin acc = 1'b1; break; end
    end
    req_valid_i = 1'b0;
    req_op_i = OW'($urandom); req_addr_a_i = AW'($urandom); req_addr_b_i = AW'($urandom);
    req_need_a_i = 1'($urandom); req_need_b_i = 1'($urandom);
    t_lat = -1; t_unstable = 0; t_ready_after = 1'b0;
    if (acc) begin
      for (int n = 1; n <= 300; n++) begin
        tick();
        if (s_iss_valid === 1'b1) begin t_lat = n; break; end
      end
    end
    if (t_lat > 0) begin
      t_op = s_op; t_opa = s_opa; t_opb = s_opb;
      for (int h = 0; h < hold; h++) begin
        tick();
        if (s_iss_valid !== 1'b1 || s_rvalid !== 1'b0 || s_req_ready !== 1'b0 ||
            s_op !== t_op || s_opa !== t_opa || s_opb !== t_opb) t_unstable++;
      end
      iss_ready_i = 1'b1;
      tick();
      iss_ready_i = 1'b0;
      if (s_iss_valid !== 1'b1) t_unstable++;
      tick();
      t_ready_after = s_req_ready;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; iss_ready_i = 1'b0;
    req_op_i = '0; req_addr_a_i = '0; req_addr_b_i = '0; req_need_a_i = 1'b0; req_need_b_i = 1'b0;
    xbuf_rhit_i = 1'b0; xbuf_rdata_i = '0;
    clear_xbuf(); stall_exp = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({req_ready_o, xbuf_rvalid_o, iss_valid_o} !== 3'b000)
      $display("FAIL reset_ctrl: got ready/rvalid/iss_valid=%b, want 000", {req_ready_o, xbuf_rvalid_o, iss_valid_o});
    else n_pass++;
    n_checks++;
    if ({xbuf_raddr_o, iss_op_o, iss_opa_o, iss_opb_o} !== '0)
      $display("FAIL reset_data: got raddr=%h op=%h opa=%h opb=%h, want 0", xbuf_raddr_o, iss_op_o, iss_opa_o, iss_opb_o);
    else n_pass++;
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (s_req_ready !== 1'b0) $display("FAIL reset_ready_first: got %b, want 0", s_req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (s_req_ready !== 1'b1) $display("FAIL reset_ready_rise: got %b, want 1", s_req_ready);
    else n_pass++;
  endtask

  task automatic test_both_hit();
    prep(8'h01, 8'h02, 1, 1, 0, 0, 32'hAAAA0001, 32'hBBBB0002);
    do_txn(6'h2A, 8'h01, 8'h02, 1, 1, 0);
    n_checks++;
    if (rd_q.size() != 2) $display("FAIL both_reads: got %0d reads, want 2", rd_q.size());
    else n_pass++;
    n_checks++;
    if (rd_q.size() != 2 || rd_q[0] !== 8'h01 || rd_q[1] !== 8'h02)
      $display("FAIL both_order: got %p, want 01 then 02", rd_q);
    else n_pass++;
    n_checks++;
    if (t_lat != 3) $display("FAIL both_latency: got %0d, want 3", t_lat);
    else n_pass++;
    n_checks++;
    if (t_opa !== 32'hAAAA0001 || t_opb !== 32'hBBBB0002 || t_op !== 6'h2A)
      $display("FAIL both_data: got op=%h opa=%h opb=%h, want 2a aaaa0001 bbbb0002", t_op, t_opa, t_opb);
    else n_pass++;
    clear_xbuf();
  endtask

  task automatic test_miss_retry();
    int base;
    base = stall_exp;
    prep(8'h03, 8'h44, 1, 0, 4, 0, 32'h12345678, 32'h0);
    do_txn(6'h11, 8'h03, 8'h44, 1, 0, 0);
    n_checks++;
    if (rd_q.size() != 5) $display("FAIL miss_reads: got %0d reads, want 5", rd_q.size());
    else n_pass++;
    n_checks++;
    if (rd_q.size() != 5 || rd_q.sum() with (int'(item != 8'h03)) != 0)
      $display("FAIL miss_addr: got %p, want five reads of 03", rd_q);
    else n_pass++;
    n_checks++;
    if (t_lat != 6) $display("FAIL miss_latency: got %0d, want 6", t_lat);
    else n_pass++;
    n_checks++;
    if (t_opa !== 32'h12345678 || t_opb !== 32'h0)
      $display("FAIL miss_data: got opa=%h opb=%h, want 12345678 0", t_opa, t_opb);
    else n_pass++;
`ifdef ALPU_OPF_STALL_CNT_EN
    n_checks++;
    if (int'(stall_cnt_o) != base + 4) $display("FAIL miss_stall_cnt: got %0d, want %0d", stall_cnt_o, base + 4);
    else n_pass++;
`endif
    clear_xbuf();
  endtask

  task automatic test_same_addr();
    prep(8'h05, 8'h05, 1, 1, 0, 0, 32'h0000CAFE, 32'h0);
    do_txn(6'h07, 8'h05, 8'h05, 1, 1, 0);
    n_checks++;
    if (rd_q.size() != 1) $display("FAIL same_reads: got %0d reads, want 1", rd_q.size());
    else n_pass++;
    n_checks++;
    if (t_opa !== 32'h0000CAFE || t_opb !== 32'h0000CAFE)
      $display("FAIL same_data: got opa=%h opb=%h, want cafe cafe", t_opa, t_opb);
    else n_pass++;
    clear_xbuf();
  endtask

  task automatic test_backpressure();
    prep(8'h30, 8'h31, 1, 1, 0, 1, 32'h01020304, 32'h05060708);
    do_txn(6'h3F, 8'h30, 8'h31, 1, 1, 2);
    n_checks++;
    if (t_unstable != 0) $display("FAIL bp_stable: got %0d unstable cycles, want 0", t_unstable);
    else n_pass++;
    n_checks++;
    if (rd_q.size() != exp_rd.size()) $display("FAIL bp_reads: got %0d, want %0d", rd_q.size(), exp_rd.size());
    else n_pass++;
    n_checks++;
    if (t_ready_after !== 1'b1) $display("FAIL bp_ready_after: got %b, want 1", t_ready_after);
    else n_pass++;
    n_checks++;
    if (t_opa !== e_opa || t_opb !== e_opb) $display("FAIL bp_data: got %h %h, want %h %h", t_opa, t_opb, e_opa, e_opb);
    else n_pass++;
    clear_xbuf();
  endtask

  task automatic test_flush();
    bit acc;
    prep(8'h10, 8'h11, 1, 1, 0, 0, 32'hD00D0010, 32'hD00D0011);
    rd_q.delete();
    req_op_i = 6'h01; req_addr_a_i = 8'h10; req_addr_b_i = 8'h11;
    req_need_a_i = 1'b1; req_need_b_i = 1'b1; req_valid_i = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_req_ready === 1'b1) begin acc = 1'b1; break; end
    end
    req_valid_i = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n_checks++;
    if (!acc || s_rvalid !== 1'b0 || s_iss_valid !== 1'b0)
      $display("FAIL flush_cycle: got accepted=%b rvalid=%b iss_valid=%b, want 1 0 0", acc, s_rvalid, s_iss_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (s_req_ready !== 1'b1 || s_iss_valid !== 1'b0 || s_rvalid !== 1'b0)
      $display("FAIL flush_idle: got ready=%b iss_valid=%b rvalid=%b, want 1 0 0", s_req_ready, s_iss_valid, s_rvalid);
    else n_pass++;
    n_checks++;
    if (rd_q.size() != 1) $display("FAIL flush_reads: got %0d reads, want 1", rd_q.size());
    else n_pass++;
    req_valid_i = 1'b1; flush_i = 1'b1; req_need_a_i = 1'b1;
    tick();
    req_valid_i = 1'b0; flush_i = 1'b0;
    tick();
    n_checks++;
    if (s_rvalid !== 1'b0 || s_req_ready !== 1'b1)
      $display("FAIL flush_blocks_req: got rvalid=%b ready=%b, want 0 1", s_rvalid, s_req_ready);
    else n_pass++;
    clear_xbuf();
    prep(8'h12, 8'h13, 1, 1, 0, 0, 32'h11112222, 32'h33334444);
    do_txn(6'h15, 8'h12, 8'h13, 1, 1, 0);
    n_checks++;
    if (t_lat != 3 || t_opa !== 32'h11112222 || t_opb !== 32'h33334444)
      $display("FAIL flush_next_txn: got lat=%0d opa=%h opb=%h, want 3 11112222 33334444", t_lat, t_opa, t_opb);
    else n_pass++;
    clear_xbuf();
  endtask

  task automatic test_reset_mid();
    prep(8'h20, 8'h21, 1, 0, 1000, 0, 32'h55555555, 32'h0);
    rd_q.delete();
    req_op_i = 6'h2C; req_addr_a_i = 8'h20; req_addr_b_i = 8'h21;
    req_need_a_i = 1'b1; req_need_b_i = 1'b0; req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready_o, xbuf_rvalid_o, iss_valid_o} !== 3'b000 ||
        {xbuf_raddr_o, iss_op_o, iss_opa_o, iss_opb_o} !== '0)
      $display("FAIL reset_mid_outputs: got ready=%b rvalid=%b iss_valid=%b raddr=%h op=%h, want all 0",
               req_ready_o, xbuf_rvalid_o, iss_valid_o, xbuf_raddr_o, iss_op_o);
    else n_pass++;
    clear_xbuf();
    stall_exp = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (s_req_ready !== 1'b0 || s_rvalid !== 1'b0) $display("FAIL reset_mid_first: got ready=%b rvalid=%b, want 0 0", s_req_ready, s_rvalid);
    else n_pass++;
    tick();
    n_checks++;
    if (s_req_ready !== 1'b1) $display("FAIL reset_mid_ready: got %b, want 1", s_req_ready);
    else n_pass++;
`ifdef ALPU_OPF_STALL_CNT_EN
    n_checks++;
    if (stall_cnt_o !== 16'd0) $display("FAIL reset_mid_stall_cnt: got %0d, want 0", stall_cnt_o);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic [AW-1:0] a, b;
      logic [OW-1:0] op;
      bit na, nb;
      int ma, mb, hold;
      op = OW'($urandom);
      a  = AW'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? a : AW'($urandom);
      na = 1'($urandom); nb = 1'($urandom);
      ma = $urandom_range(0, 3); mb = $urandom_range(0, 3);
      hold = $urandom_range(0, 2);
      prep(a, b, na, nb, ma, mb, $urandom, $urandom);
      do_txn(op, a, b, na, nb, hold);
      n_checks++;
      if (rd_q.size() != exp_rd.size()) $display("FAIL rnd%0d_nreads: got %0d, want %0d", t, rd_q.size(), exp_rd.size());
      else n_pass++;
      for (int i = 0; i < exp_rd.size(); i++) begin
        logic [AW-1:0] got;
        got = (i < rd_q.size()) ? rd_q[i] : 'x;
        n_checks++;
        if (got !== exp_rd[i]) $display("FAIL rnd%0d_raddr%0d: got %h, want %h", t, i, got, exp_rd[i]);
        else n_pass++;
      end
      n_checks++;
      if (t_lat != e_lat) $display("FAIL rnd%0d_latency: got %0d, want %0d", t, t_lat, e_lat);
      else n_pass++;
      n_checks++;
      if (t_op !== op || t_opa !== e_opa || t_opb !== e_opb)
        $display("FAIL rnd%0d_data: got op=%h opa=%h opb=%h, want %h %h %h", t, t_op, t_opa, t_opb, op, e_opa, e_opb);
      else n_pass++;
      n_checks++;
      if (t_unstable != 0 || t_ready_after !== 1'b1)
        $display("FAIL rnd%0d_issue: got unstable=%0d ready_after=%b, want 0 1", t, t_unstable, t_ready_after);
      else n_pass++;
      clear_xbuf();
    end
`ifdef ALPU_OPF_STALL_CNT_EN
    n_checks++;
    if (int'(stall_cnt_o) != stall_exp) $display("FAIL rnd_stall_cnt: got %0d, want %0d", stall_cnt_o, stall_exp);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_both_hit();
    test_miss_retry();
    test_same_addr();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
